// File: rtl/piso_serializer_pkg.sv
// ---------------------------------------------------------------------------
// piso_serializer_pkg
//
// Shared definitions for the parallel-in / serial-out serializer.
//   state_t        : FSM state encoding (IDLE, SHIFT)
//   DEFAULT_WIDTH  : default word length in bits
//   cnt_width()    : width of the bit counter for a given word length
// ---------------------------------------------------------------------------
package piso_serializer_pkg;

  // IDLE  : nothing on the serial line
  // SHIFT : a word is being shifted out, one bit per clock
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width. Every legal WIDTH (2..32) yields at least one bit,
  // and the counter only ever holds values 0..WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Accepts a parallel word over a valid/ready handshake and shifts it out one
// bit per clock. A one-entry holding buffer lets the next word be accepted
// while the current one is still shifting, so consecutive words go out with
// no idle cycle between frames.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clock_in      in   sole clock, rising edge
//   reset         in   asynchronous, active-high reset
//   data_in       in   parallel word offered for transfer
//   data_valid    in   data_in holds a word
//   data_ready    out  a word can be accepted this cycle (buffer empty)
//   serial_out    out  current serial bit (0 when idle)
//   serial_valid  out  serial_out carries a frame bit
//   frame_start   out  pulse alongside the first bit of each word
//   frame_end     out  pulse alongside the last bit of each word
//   busy          out  shifting, or the holding buffer is full
//   state_dbg     out  current FSM state, for observation only
//
// Handshake: a word is transferred on a rising edge of clock_in where
// data_valid and data_ready are both high. data_ready depends only on the
// holding buffer, never on data_valid, so there is no combinational path
// from data_valid to data_ready. data_in is ignored in every other cycle.
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic             transfer;
  logic             in_shift;
  logic             last_bit;
  logic [WIDTH-1:0] shift_next;
  logic             current_bit;

  assign transfer = data_valid && !hold_full_q;
  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (cnt_q == CNT_LAST);

  // The outgoing bit always sits at one fixed end of the register; each
  // cycle the register moves one place toward that end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next  = {shift_q[WIDTH-2:0], 1'b0};
      assign current_bit = shift_q[WIDTH-1];
    end else begin : g_lsb_first
      assign shift_next  = {1'b0, shift_q[WIDTH-1:1]};
      assign current_bit = shift_q[0];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    unique case (state_q)
      IDLE: begin
        // The buffer is always empty here, so data_ready is high and a
        // valid word goes straight into the shift register.
        if (transfer) begin
          shift_d = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // Last bit: pick the next word so its first bit follows with no
          // gap. A buffered word is older than anything on data_in, so it
          // wins; data_ready is low in that case anyway.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_d      = '0;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (transfer) begin
            shift_d = data_in;
            cnt_d   = '0;
          end else begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          shift_d = shift_next;
          cnt_d   = cnt_q + CNT_ONE;
          if (transfer) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all decoded from registers, so the asynchronous reset drives
  // them to their idle values at once.
  // -------------------------------------------------------------------------
  assign data_ready   = !hold_full_q;
  assign serial_valid = in_shift;
  assign serial_out   = in_shift && current_bit;
  assign frame_start  = in_shift && (cnt_q == '0);
  assign frame_end    = last_bit;
  assign busy         = in_shift || hold_full_q;
  assign state_dbg    = state_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//
// Directed bench for piso_serializer. Two instances share clock and reset:
// dut_m (MSB first) and dut_l (LSB first), both WIDTH = 8. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int W = 8;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // MSB-first instance signals
  logic [W-1:0] m_data_in    = '0;
  logic         m_data_valid = 1'b0;
  logic         m_data_ready, m_serial_out, m_serial_valid;
  logic         m_frame_start, m_frame_end, m_busy;
  state_t       m_state;

  // LSB-first instance signals
  logic [W-1:0] l_data_in    = '0;
  logic         l_data_valid = 1'b0;
  logic         l_data_ready, l_serial_out, l_serial_valid;
  logic         l_frame_start, l_frame_end, l_busy;
  state_t       l_state;

  int n_checks = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clock_in     (clk),
    .reset        (rst),
    .data_in      (m_data_in),
    .data_valid   (m_data_valid),
    .data_ready   (m_data_ready),
    .serial_out   (m_serial_out),
    .serial_valid (m_serial_valid),
    .frame_start  (m_frame_start),
    .frame_end    (m_frame_end),
    .busy         (m_busy),
    .state_dbg    (m_state)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock_in     (clk),
    .reset        (rst),
    .data_in      (l_data_in),
    .data_valid   (l_data_valid),
    .data_ready   (l_data_ready),
    .serial_out   (l_serial_out),
    .serial_valid (l_serial_valid),
    .frame_start  (l_frame_start),
    .frame_end    (l_frame_end),
    .busy         (l_busy),
    .state_dbg    (l_state)
  );

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (m_data_ready !== 1'b1) begin n_fail++; $display("FAIL reset data_ready: got %b want 1", m_data_ready); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", m_busy); end
    n_checks++; if (m_serial_valid !== 1'b0) begin n_fail++; $display("FAIL reset serial_valid: got %b want 0", m_serial_valid); end
    n_checks++; if (m_serial_out !== 1'b0) begin n_fail++; $display("FAIL reset serial_out: got %b want 0", m_serial_out); end
    n_checks++; if ({m_frame_start, m_frame_end} !== 2'b00) begin n_fail++; $display("FAIL reset frame flags: got %b want 00", {m_frame_start, m_frame_end}); end
    n_checks++; if (m_state !== IDLE) begin n_fail++; $display("FAIL reset state: got %0d want IDLE", m_state); end
    n_checks++; if ({l_data_ready, l_busy, l_serial_valid} !== 3'b100) begin n_fail++; $display("FAIL reset lsb ready/busy/valid: got %b want 100", {l_data_ready, l_busy, l_serial_valid}); end
    rst = 1'b0;
    // data_in toggling with data_valid low must not start a frame
    m_data_in = 8'hFF;
    @(negedge clk);
    m_data_in = 8'h3C;
    @(negedge clk);
    n_checks++; if ({m_serial_valid, m_busy} !== 2'b00) begin n_fail++; $display("FAIL idle_no_valid valid/busy: got %b want 00", {m_serial_valid, m_busy}); end
  endtask

  task automatic test_single();
    logic [W-1:0] w = 8'hB8;
    @(negedge clk);
    m_data_in = w; m_data_valid = 1'b1;
    @(negedge clk);
    m_data_valid = 1'b0;
    m_data_in = 8'h00;  // not sampled: no transfer
    for (int i = 0; i < W; i++) begin
      n_checks++; if (m_serial_valid !== 1'b1) begin n_fail++; $display("FAIL single valid bit%0d: got %b want 1", i, m_serial_valid); end
      n_checks++; if (m_serial_out !== w[W-1-i]) begin n_fail++; $display("FAIL single serial_out bit%0d: got %b want %b", i, m_serial_out, w[W-1-i]); end
      n_checks++; if (m_frame_start !== (i == 0)) begin n_fail++; $display("FAIL single frame_start bit%0d: got %b want %b", i, m_frame_start, (i == 0)); end
      n_checks++; if (m_frame_end !== (i == W-1)) begin n_fail++; $display("FAIL single frame_end bit%0d: got %b want %b", i, m_frame_end, (i == W-1)); end
      @(negedge clk);
    end
    n_checks++; if ({m_serial_valid, m_serial_out, m_busy, m_data_ready} !== 4'b0001) begin n_fail++; $display("FAIL single after valid/out/busy/ready: got %b want 0001", {m_serial_valid, m_serial_out, m_busy, m_data_ready}); end
    n_checks++; if (m_state !== IDLE) begin n_fail++; $display("FAIL single after state: got %0d want IDLE", m_state); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] seq = 16'hB85A;
    @(negedge clk);
    m_data_in = 8'hB8; m_data_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2*W; i++) begin
      if (i == 0) m_data_in = 8'h5A;   // accepted into the holding buffer
      if (i == 1) m_data_valid = 1'b0;
      n_checks++; if (m_serial_valid !== 1'b1) begin n_fail++; $display("FAIL b2b valid bit%0d: got %b want 1", i, m_serial_valid); end
      n_checks++; if (m_serial_out !== seq[2*W-1-i]) begin n_fail++; $display("FAIL b2b serial_out bit%0d: got %b want %b", i, m_serial_out, seq[2*W-1-i]); end
      n_checks++; if (m_data_ready !== !(i >= 1 && i <= W-1)) begin n_fail++; $display("FAIL b2b data_ready bit%0d: got %b want %b", i, m_data_ready, !(i >= 1 && i <= W-1)); end
      n_checks++; if (m_frame_start !== (i == 0 || i == W)) begin n_fail++; $display("FAIL b2b frame_start bit%0d: got %b want %b", i, m_frame_start, (i == 0 || i == W)); end
      n_checks++; if (m_frame_end !== (i == W-1 || i == 2*W-1)) begin n_fail++; $display("FAIL b2b frame_end bit%0d: got %b want %b", i, m_frame_end, (i == W-1 || i == 2*W-1)); end
      n_checks++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL b2b busy bit%0d: got %b want 1", i, m_busy); end
      @(negedge clk);
    end
    n_checks++; if ({m_serial_valid, m_busy} !== 2'b00) begin n_fail++; $display("FAIL b2b after valid/busy: got %b want 00", {m_serial_valid, m_busy}); end
  endtask

  task automatic test_last_bit_load();
    logic [2*W-1:0] seq = 16'hB80F;
    @(negedge clk);
    m_data_in = 8'hB8; m_data_valid = 1'b1;
    @(negedge clk);
    m_data_valid = 1'b0;
    for (int i = 0; i < 2*W; i++) begin
      if (i == W-1) begin m_data_in = 8'h0F; m_data_valid = 1'b1; end
      if (i == W)   m_data_valid = 1'b0;
      n_checks++; if (m_serial_valid !== 1'b1) begin n_fail++; $display("FAIL lastload valid bit%0d: got %b want 1", i, m_serial_valid); end
      n_checks++; if (m_serial_out !== seq[2*W-1-i]) begin n_fail++; $display("FAIL lastload serial_out bit%0d: got %b want %b", i, m_serial_out, seq[2*W-1-i]); end
      n_checks++; if (m_data_ready !== 1'b1) begin n_fail++; $display("FAIL lastload data_ready bit%0d: got %b want 1", i, m_data_ready); end
      n_checks++; if (m_frame_start !== (i == 0 || i == W)) begin n_fail++; $display("FAIL lastload frame_start bit%0d: got %b want %b", i, m_frame_start, (i == 0 || i == W)); end
      @(negedge clk);
    end
    n_checks++; if ({m_serial_valid, m_busy} !== 2'b00) begin n_fail++; $display("FAIL lastload after valid/busy: got %b want 00", {m_serial_valid, m_busy}); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w  = 8'hB8;
    logic [W-1:0] w2 = 8'h81;
    @(negedge clk);
    m_data_in = w; m_data_valid = 1'b1;
    @(negedge clk);
    m_data_in = 8'h5A;  // buffered on the next edge
    for (int i = 0; i < 3; i++) begin
      if (i == 1) m_data_valid = 1'b0;
      n_checks++; if (m_serial_out !== w[W-1-i]) begin n_fail++; $display("FAIL midrst pre bit%0d: got %b want %b", i, m_serial_out, w[W-1-i]); end
      @(negedge clk);
    end
    n_checks++; if ({m_busy, m_data_ready} !== 2'b10) begin n_fail++; $display("FAIL midrst buffered busy/ready: got %b want 10", {m_busy, m_data_ready}); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({m_serial_valid, m_serial_out, m_frame_start, m_frame_end} !== 4'b0000) begin n_fail++; $display("FAIL midrst async outputs: got %b want 0000", {m_serial_valid, m_serial_out, m_frame_start, m_frame_end}); end
    n_checks++; if ({m_busy, m_data_ready} !== 2'b01) begin n_fail++; $display("FAIL midrst async busy/ready: got %b want 01", {m_busy, m_data_ready}); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++; if ({m_serial_valid, m_frame_end, m_busy} !== 3'b000) begin n_fail++; $display("FAIL midrst quiet cycle%0d valid/end/busy: got %b want 000", i, {m_serial_valid, m_frame_end, m_busy}); end
    end
    m_data_in = w2; m_data_valid = 1'b1;
    @(negedge clk);
    m_data_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      n_checks++; if (m_serial_valid !== 1'b1 || m_serial_out !== w2[W-1-i]) begin n_fail++; $display("FAIL midrst post bit%0d valid/out: got %b%b want 1%b", i, m_serial_valid, m_serial_out, w2[W-1-i]); end
      n_checks++; if (m_frame_end !== (i == W-1)) begin n_fail++; $display("FAIL midrst post frame_end bit%0d: got %b want %b", i, m_frame_end, (i == W-1)); end
      @(negedge clk);
    end
    n_checks++; if ({m_serial_valid, m_busy} !== 2'b00) begin n_fail++; $display("FAIL midrst end valid/busy: got %b want 00", {m_serial_valid, m_busy}); end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] exp_bits = 8'b0001_1101;  // B8 sent bit0 first: 0,0,0,1,1,1,0,1
    @(negedge clk);
    l_data_in = 8'hB8; l_data_valid = 1'b1;
    @(negedge clk);
    l_data_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      n_checks++; if (l_serial_valid !== 1'b1) begin n_fail++; $display("FAIL lsb valid bit%0d: got %b want 1", i, l_serial_valid); end
      n_checks++; if (l_serial_out !== exp_bits[W-1-i]) begin n_fail++; $display("FAIL lsb serial_out bit%0d: got %b want %b", i, l_serial_out, exp_bits[W-1-i]); end
      n_checks++; if ({l_frame_start, l_frame_end} !== {(i == 0), (i == W-1)}) begin n_fail++; $display("FAIL lsb frame flags bit%0d: got %b%b want %b%b", i, l_frame_start, l_frame_end, (i == 0), (i == W-1)); end
      @(negedge clk);
    end
    n_checks++; if ({l_serial_valid, l_busy, l_state} !== {2'b00, IDLE}) begin n_fail++; $display("FAIL lsb after valid/busy/state: got %b want 000", {l_serial_valid, l_busy, l_state}); end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_last_bit_load();
    test_reset_mid();
    test_lsb_first();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the test sequence completed");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_piso_serializer

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 clock_in  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  WIDTH  parallel word to transmit.
REQ-006 data_valid  input  1  data_in holds a word offered for transfer.
REQ-007 data_ready  output  1  block can accept a word this cycle.
REQ-008 serial_out  output  1  current serial bit.
REQ-009 serial_valid  output  1  serial_out carries a frame bit.
REQ-010 frame_start  output  1  one-cycle pulse with the first bit of each word.
REQ-011 frame_end  output  1  one-cycle pulse with the last bit of each word.
REQ-012 busy  output  1  high when shifting or when the holding buffer is full.

Function
REQ-013 A transfer occurs on a rising edge where data_valid and data_ready are both high; there is no other way to accept a word.
REQ-014 data_ready is combinational: high exactly when the one-entry holding buffer is empty.
REQ-015 States: IDLE (no word shifting) and SHIFT (a word is being shifted, bit counter 0..WIDTH-1).
REQ-016 IDLE with transfer: load the word into the shift register, clear the counter, go to SHIFT; the first bit appears on serial_out in the next cycle (one-cycle latency).
REQ-017 SHIFT with transfer: store the word in the holding buffer; data_ready drops next cycle.
REQ-018 In SHIFT, serial_valid is 1 and serial_out equals the current bit; the counter increments each cycle.
REQ-019 frame_start is 1 when the counter is 0; frame_end is 1 when the counter is WIDTH-1.
REQ-020 Last bit (counter = WIDTH-1), priority order: buffer full -> load buffer word, empty buffer, stay in SHIFT; else transfer this cycle -> load data_in directly, stay in SHIFT; else go to IDLE.
REQ-021 Consecutive words are sent with zero idle cycles: frame_end of word N is followed in the next cycle by frame_start of word N+1.
REQ-022 In IDLE, serial_out = 0, serial_valid = 0, frame_start = 0, frame_end = 0.
REQ-023 Bit order within a word is fixed by MSB_FIRST; counter width is clog2(WIDTH) bits and never exceeds WIDTH-1.
REQ-024 data_in is not sampled in cycles without a transfer; changes to data_in while data_valid is low have no effect.

Reset
REQ-025 Asserting reset immediately forces IDLE, clears the shift register, counter and holding buffer, and drives serial_out = 0, serial_valid = 0, frame_start = 0, frame_end = 0, busy = 0, data_ready = 1.
REQ-026 Reset mid-frame discards both the partially sent word and any buffered word; no frame_end is produced for them.
REQ-027 After reset deasserts, the first transfer is accepted on the first rising edge where data_valid is high.

Structure
REQ-028 A shared package holds the state enumeration (IDLE, SHIFT) and the default WIDTH constant.
REQ-029 Single module with no sub-modules; the holding buffer, shift register, counter and FSM are all local to piso_serializer.

Verification
REQ-030 Reset: assert reset for 2 cycles at time 0 -> data_ready = 1, busy = 0, serial_valid = 0, serial_out = 0.
REQ-031 Single word, MSB_FIRST=1: transfer 8'hB8 in IDLE -> serial_out 1,0,1,1,1,0,0,0 over 8 cycles starting the next cycle; frame_start on bit 1, frame_end on bit 8; then IDLE.
REQ-032 Back-to-back: data_valid held with 8'hB8 then 8'h5A -> 16 contiguous valid bits 10111000 01011010; data_ready low while the buffer is full; no gap between frames.
REQ-033 Last-bit direct load: buffer empty, data_valid with 8'h0F arrives only in the last-bit cycle of 8'hB8 -> 8'h0F starts in the next cycle with no gap.
REQ-034 Reset mid-operation: assert reset after 3 bits of 8'hB8 with 8'h5A buffered -> outputs go to reset values immediately; no further bits; next transfer 8'h81 is sent cleanly.
REQ-035 LSB-first: MSB_FIRST=0, transfer 8'hB8 -> serial_out 0,0,0,1,1,1,0,1.
